// File: rtl/ps2_keyboard_receiver.sv
// rtl/ps2_keyboard_receiver.sv - PS/2 keyboard receiver with clock filter, deframer and jump-key decode
module ps2_keyboard_receiver #(
    parameter int          FILTER_LEN     = 8,
    parameter int          TIMEOUT_CYCLES = 10000,
    parameter logic [7:0]  JUMP_CODE      = 8'h29
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       frame_error,
    output logic       jump,
    output logic       jump_held
);

    localparam int         TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [8:0] FLT_LEN9 = 9'(FILTER_LEN);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic [7:0]    flt_cnt_q, flt_cnt_d;
    logic          filt_q, filt_d;
    logic          filt_prev_q;
    logic          fall;
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]    scan_code_q, scan_code_d;
    logic          code_valid_q, code_valid_d;
    logic          frame_error_q, frame_error_d;
    logic          jump_q, jump_d;
    logic          jump_held_q, jump_held_d;
    logic          brk_pend_q, brk_pend_d;
    logic          ext_pend_q, ext_pend_d;

    assign fall        = filt_prev_q & ~filt_q;
    assign scan_code   = scan_code_q;
    assign code_valid  = code_valid_q;
    assign frame_error = frame_error_q;
    assign jump        = jump_q;
    assign jump_held   = jump_held_q;

    // Filtered clock follows the synchronized clock only after it holds a new level FILTER_LEN cycles
    always_comb begin
        flt_cnt_d = '0;
        filt_d    = filt_q;
        if (clk_s2_q != filt_q) begin
            if ({1'b0, flt_cnt_q} + 9'd1 == FLT_LEN9) begin
                filt_d = clk_s2_q;
            end else begin
                flt_cnt_d = flt_cnt_q + 8'd1;
            end
        end
    end

    // Deframing FSM, inter-edge timeout and prefix/jump-key tracking
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        parity_d      = parity_q;
        to_cnt_d      = '0;
        scan_code_d   = scan_code_q;
        code_valid_d  = 1'b0;
        frame_error_d = 1'b0;
        jump_d        = 1'b0;
        jump_held_d   = jump_held_q;
        brk_pend_d    = brk_pend_q;
        ext_pend_d    = ext_pend_q;
        if (fall) begin
            // a falling edge always wins over a coincident timeout
            case (state_q)
                IDLE: begin
                    if (!dat_s2_q) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                DATA: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parity_d = dat_s2_q;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (dat_s2_q && (^{shift_q, parity_q})) begin
                        scan_code_d  = shift_q;
                        code_valid_d = 1'b1;
                        if (shift_q == 8'hF0) begin
                            brk_pend_d = 1'b1;
                        end else if (shift_q == 8'hE0) begin
                            ext_pend_d = 1'b1;
                        end else begin
                            brk_pend_d = 1'b0;
                            ext_pend_d = 1'b0;
                            if (!ext_pend_q && shift_q == JUMP_CODE) begin
                                if (brk_pend_q) begin
                                    jump_held_d = 1'b0;
                                end else if (!jump_held_q) begin
                                    jump_d      = 1'b1;
                                    jump_held_d = 1'b1;
                                end
                            end
                        end
                    end else begin
                        frame_error_d = 1'b1;
                        brk_pend_d    = 1'b0;
                        ext_pend_d    = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (to_cnt_q == TO_LAST) begin
                state_d       = IDLE;
                frame_error_d = 1'b1;
                brk_pend_d    = 1'b0;
                ext_pend_d    = 1'b0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    // State registers; line-side flops reset to the idle-high level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s1_q      <= 1'b1;
            clk_s2_q      <= 1'b1;
            dat_s1_q      <= 1'b1;
            dat_s2_q      <= 1'b1;
            flt_cnt_q     <= '0;
            filt_q        <= 1'b1;
            filt_prev_q   <= 1'b1;
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            parity_q      <= 1'b0;
            to_cnt_q      <= '0;
            scan_code_q   <= '0;
            code_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            jump_q        <= 1'b0;
            jump_held_q   <= 1'b0;
            brk_pend_q    <= 1'b0;
            ext_pend_q    <= 1'b0;
        end else begin
            clk_s1_q      <= ps2_clk;
            clk_s2_q      <= clk_s1_q;
            dat_s1_q      <= ps2_data;
            dat_s2_q      <= dat_s1_q;
            flt_cnt_q     <= flt_cnt_d;
            filt_q        <= filt_d;
            filt_prev_q   <= filt_q;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            parity_q      <= parity_d;
            to_cnt_q      <= to_cnt_d;
            scan_code_q   <= scan_code_d;
            code_valid_q  <= code_valid_d;
            frame_error_q <= frame_error_d;
            jump_q        <= jump_d;
            jump_held_q   <= jump_held_d;
            brk_pend_q    <= brk_pend_d;
            ext_pend_q    <= ext_pend_d;
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// tb/tb_ps2_keyboard_receiver.sv - directed self-checking bench for ps2_keyboard_receiver
module tb_ps2_keyboard_receiver;

    localparam int TO  = 300;
    localparam int LAT = 11;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scan_code;
    logic       code_valid, frame_error, jump, jump_held;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cv_count = 0, fe_count = 0, jump_count = 0, both_count = 0;
    int cv_cycle = 0, fe_cycle = 0, jump_cycle = 0, held_fall_cycle = 0;
    int t_fall = 0, t_stop = 0;
    logic held_prev = 1'b0;

    ps2_keyboard_receiver #(
        .FILTER_LEN(8),
        .TIMEOUT_CYCLES(TO),
        .JUMP_CODE(8'h29)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .scan_code(scan_code),
        .code_valid(code_valid),
        .frame_error(frame_error),
        .jump(jump),
        .jump_held(jump_held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (code_valid) begin cv_count++; cv_cycle = cyc; end
        if (frame_error) begin fe_count++; fe_cycle = cyc; end
        if (jump) begin jump_count++; jump_cycle = cyc; end
        if (code_valid && frame_error) both_count++;
        if (held_prev && !jump_held) held_fall_cycle = cyc;
        held_prev = jump_held;
    end

    task automatic clear_counts();
        @(posedge clk); #1;
        cv_count = 0; fe_count = 0; jump_count = 0;
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b0;
        t_fall = cyc;
        repeat (20) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad);
        send_bit(1'b1);
        t_stop = t_fall;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (scan_code !== 8'h00) begin errors++; $display("FAIL reset_scan_code got %h want 00", scan_code); end
        checks++; if ({code_valid, frame_error, jump, jump_held} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b want 0000", {code_valid, frame_error, jump, jump_held}); end
        repeat (3) @(negedge clk);
        checks++; if ({code_valid, frame_error, jump, jump_held} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags_clocked got %b want 0000", {code_valid, frame_error, jump, jump_held}); end
        reset = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single_make();
        clear_counts();
        send_frame(8'h1C, 1'b0);
        checks++; if (cv_count !== 1) begin errors++; $display("FAIL make_cv_count got %0d want 1", cv_count); end
        checks++; if (scan_code !== 8'h1C) begin errors++; $display("FAIL make_scan got %h want 1c", scan_code); end
        checks++; if (jump_count !== 0) begin errors++; $display("FAIL make_jump got %0d want 0", jump_count); end
        checks++; if (fe_count !== 0) begin errors++; $display("FAIL make_fe got %0d want 0", fe_count); end
        checks++; if (cv_cycle !== t_stop + LAT) begin errors++; $display("FAIL make_latency got %0d want %0d", cv_cycle, t_stop + LAT); end
    endtask

    task automatic test_jump_sequence();
        clear_counts();
        send_frame(8'h29, 1'b0);
        checks++; if (jump_count !== 1 || jump_held !== 1'b1) begin
            errors++; $display("FAIL jump_first got count %0d held %b want 1 1", jump_count, jump_held); end
        checks++; if (jump_cycle !== cv_cycle) begin errors++; $display("FAIL jump_align got %0d want %0d", jump_cycle, cv_cycle); end
        send_frame(8'h29, 1'b0);
        checks++; if (jump_count !== 1 || jump_held !== 1'b1) begin
            errors++; $display("FAIL jump_repeat got count %0d held %b want 1 1", jump_count, jump_held); end
        send_frame(8'hF0, 1'b0);
        checks++; if (jump_held !== 1'b1 || scan_code !== 8'hF0) begin
            errors++; $display("FAIL jump_f0 got held %b scan %h want 1 f0", jump_held, scan_code); end
        send_frame(8'h29, 1'b0);
        checks++; if (jump_held !== 1'b0) begin errors++; $display("FAIL jump_break got held %b want 0", jump_held); end
        checks++; if (held_fall_cycle !== cv_cycle) begin errors++; $display("FAIL jump_release_align got %0d want %0d", held_fall_cycle, cv_cycle); end
        checks++; if (cv_count !== 4 || jump_count !== 1) begin
            errors++; $display("FAIL jump_totals got cv %0d jump %0d want 4 1", cv_count, jump_count); end
    endtask

    task automatic test_extended();
        clear_counts();
        send_frame(8'hE0, 1'b0);
        send_frame(8'h29, 1'b0);
        checks++; if (jump_count !== 0 || jump_held !== 1'b0) begin
            errors++; $display("FAIL ext_jump got count %0d held %b want 0 0", jump_count, jump_held); end
        checks++; if (scan_code !== 8'h29 || cv_count !== 2) begin
            errors++; $display("FAIL ext_scan got %h cv %0d want 29 2", scan_code, cv_count); end
    endtask

    task automatic test_parity_error();
        send_frame(8'h15, 1'b0);
        clear_counts();
        send_frame(8'h29, 1'b1);
        checks++; if (fe_count !== 1 || cv_count !== 0) begin
            errors++; $display("FAIL par_flags got fe %0d cv %0d want 1 0", fe_count, cv_count); end
        checks++; if (scan_code !== 8'h15) begin errors++; $display("FAIL par_scan_hold got %h want 15", scan_code); end
        checks++; if (jump_count !== 0 || jump_held !== 1'b0) begin
            errors++; $display("FAIL par_jump got count %0d held %b want 0 0", jump_count, jump_held); end
        checks++; if (fe_cycle !== t_stop + LAT) begin errors++; $display("FAIL par_latency got %0d want %0d", fe_cycle, t_stop + LAT); end
        send_frame(8'h1C, 1'b0);
        checks++; if (scan_code !== 8'h1C || cv_count !== 1) begin
            errors++; $display("FAIL par_recover got %h cv %0d want 1c 1", scan_code, cv_count); end
    endtask

    task automatic test_error_clears_break();
        clear_counts();
        send_frame(8'h29, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h33, 1'b1);
        send_frame(8'h29, 1'b0);
        checks++; if (jump_held !== 1'b1 || jump_count !== 1) begin
            errors++; $display("FAIL errbrk_held got held %b count %0d want 1 1", jump_held, jump_count); end
        send_frame(8'hF0, 1'b0);
        send_frame(8'h29, 1'b0);
        checks++; if (jump_held !== 1'b0) begin errors++; $display("FAIL errbrk_release got held %b want 0", jump_held); end
    endtask

    task automatic test_glitch_timeout();
        int last;
        clear_counts();
        @(negedge clk);
        ps2_data = 1'b0;
        ps2_clk = 1'b0;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (40) @(negedge clk);
        ps2_data = 1'b1;
        @(posedge clk); #1;
        checks++; if (fe_count !== 0 || cv_count !== 0) begin
            errors++; $display("FAIL glitch got fe %0d cv %0d want 0 0", fe_count, cv_count); end
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        last = t_fall;
        for (int k = 0; k < TO + 100 && fe_count == 0; k++) @(posedge clk);
        #1;
        checks++; if (fe_count !== 1) begin errors++; $display("FAIL timeout_seen got %0d want 1", fe_count); end
        checks++; if (fe_cycle !== last + LAT + TO) begin
            errors++; $display("FAIL timeout_latency got %0d want %0d", fe_cycle, last + LAT + TO); end
        send_frame(8'h1C, 1'b0);
        checks++; if (scan_code !== 8'h1C || cv_count !== 1 || fe_count !== 1) begin
            errors++; $display("FAIL timeout_recover got %h cv %0d fe %0d want 1c 1 1", scan_code, cv_count, fe_count); end
    endtask

    task automatic test_mid_reset();
        send_frame(8'h5A, 1'b0);
        clear_counts();
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'(8'h29 >> i));
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (scan_code !== 8'h00) begin errors++; $display("FAIL rst_scan got %h want 00", scan_code); end
        repeat (20) @(negedge clk);
        checks++; if ({code_valid, frame_error, jump, jump_held} !== 4'b0000) begin
            errors++; $display("FAIL rst_flags got %b want 0000", {code_valid, frame_error, jump, jump_held}); end
        reset = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h1C, 1'b0);
        checks++; if (fe_count !== 0) begin errors++; $display("FAIL rst_no_fe got %0d want 0", fe_count); end
        checks++; if (scan_code !== 8'h1C || cv_count !== 1) begin
            errors++; $display("FAIL rst_recover got %h cv %0d want 1c 1", scan_code, cv_count); end
    endtask

    initial begin
        test_reset();
        test_single_make();
        test_jump_sequence();
        test_extended();
        test_parity_error();
        test_error_clears_break();
        test_glitch_timeout();
        test_mid_reset();
        checks++; if (both_count !== 0) begin errors++; $display("FAIL exclusive got %0d want 0", both_count); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_receiver.md
# ps2_keyboard_receiver

Receive-only PS/2 keyboard front end for the game's IO controller, the input-side counterpart to the VGA output path. It synchronizes and deglitches the keyboard's clock and data lines and deframes 11-bit PS/2 frames into scan-code bytes. It tracks the F0 (break) and E0 (extended) prefixes and turns make and break codes of the configured key into the `jump` pulse and held level consumed by the game logic. It never drives the PS/2 lines.

## Interface
Parameters:
- `FILTER_LEN`, 8: consecutive `clk` cycles the synchronized ps2_clk must hold a new level before the filtered clock follows it; range 2–255.
- `TIMEOUT_CYCLES`, 10000: maximum idle `clk` cycles between falling edges inside a frame (100 µs at 100 MHz).
- `JUMP_CODE`, 8'h29: scan code of the jump key (space bar), non-extended only.

Ports:
- `clk`  in  1  100 MHz system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock from the pin (idle high).
- `ps2_data`  in  1  raw PS/2 data from the pin (idle high).
- `scan_code`  out  8  last valid received byte. Held until the next valid byte.
- `code_valid`  out  1  one-cycle pulse; `scan_code` is updated in the same cycle.
- `frame_error`  out  1  one-cycle pulse on a parity error, bad stop bit, or timeout.
- `jump`  out  1  one-cycle pulse on the first make of `JUMP_CODE`.
- `jump_held`  out  1  level; high from the jump make until the jump break.

## Operation
- **Synchronizer.** Two flops `s1`, `s2` sample `ps2_clk`. A second two-flop chain samples `ps2_data`. All four flops reset to 1.
- **Filter.**
  - `filt` resets to 1.
  - A counter increments each cycle while `s2 != filt` and clears whenever `s2 == filt`.
  - `filt <= s2` on the cycle the counter would reach `FILTER_LEN`.
  - Glitches shorter than `FILTER_LEN` cycles are rejected.
- **Edge detect.** `fall = filt_prev & ~filt`. Data is sampled from the synchronized data in the `fall` cycle.
- **FSM states:** IDLE, DATA, PARITY, STOP. All transitions happen on `fall`.
  - IDLE: data=0 → DATA with bit count 0. Data=1 → stay in IDLE, no error.
  - DATA: shift in LSB first. After the 8th bit → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP: capture the stop bit → IDLE. The frame is valid iff stop=1 and the XOR of the 8 data bits and the parity bit equals 1 (odd parity).
- **Valid frame.**
  - Update `scan_code` and pulse `code_valid`. This applies to every byte, including F0 and E0.
  - 8'hF0 sets `brk_pend`. 8'hE0 sets `ext_pend`.
  - Any other byte is a key event; it consumes and clears both pending flags.
- **Invalid frame.** Pulse `frame_error`. `scan_code` is unchanged. Clear `brk_pend` and `ext_pend`.
- **Timeout.**
  - In any state other than IDLE, a counter counts cycles since the last `fall`.
  - When it reaches `TIMEOUT_CYCLES`: go to IDLE, pulse `frame_error`, discard the partial frame, clear the pending flags.
- **Jump logic.** Applies only to key events with `ext_pend`=0.
  - Make of `JUMP_CODE` with `jump_held`=0: pulse `jump` and set `jump_held`.
  - Make while `jump_held`=1 (typematic repeat): no pulse.
  - Break of `JUMP_CODE`: clear `jump_held`.
  - E0-prefixed 29 has no effect on the jump outputs.
  - Other keys have no effect on the jump outputs.

## Timing
- **Reset.** While `reset`=0, regardless of `clk`:
  - all outputs are 0;
  - the FSM is in IDLE;
  - all counters are 0;
  - `filt`, `filt_prev` and all synchronizer flops are 1.
  
  Reset asserted mid-frame discards the frame with no `frame_error`.
- **Latency.** Let edge N be the first `clk` edge at which `s1` captures the stop-bit falling level.
  - `filt` falls at edge N+1+`FILTER_LEN`.
  - `code_valid` (or `frame_error`), `scan_code`, `jump` and `jump_held` all update at edge N+2+`FILTER_LEN`. With the defaults that is N+10.
- **Pulse widths.** `code_valid`, `frame_error` and `jump` are each exactly 1 cycle. `code_valid` and `frame_error` are mutually exclusive.
- **Simultaneous events.** If a timeout and a `fall` occur in the same cycle, the `fall` wins (it is processed; the counter clears).
- **Back-to-back frames.** A frame arriving immediately after a stop bit is accepted. There is no dead time beyond the filter.

## Test plan
- **Single make code.** Reset, then release reset. Send frame 0x1C (parity 0, ~80 µs clock period) → `code_valid` once, `scan_code`=8'h1C, `jump`=0, no `frame_error`.
- **Jump make, repeat, break.** Send 0x29, 0x29, F0, 0x29 → `jump` pulses exactly once (after the first byte). `jump_held` is high from that pulse until the `code_valid` of the final 0x29, then 0. Four `code_valid` pulses in total.
- **Extended code.** Send E0, 0x29 → `jump` and `jump_held` stay 0; `scan_code` ends at 8'h29.
- **Parity error.** Send 0x29 with flipped parity → `frame_error` one cycle, no `code_valid`, `scan_code` holds its prior value, `jump`=0. The following good 0x1C is accepted.
- **Glitch and timeout.**
  - A 5-cycle low glitch on `ps2_clk` causes no state change.
  - Stop the clock after 4 data bits → `frame_error` exactly `TIMEOUT_CYCLES` cycles after the last `fall`.
  - A subsequent 0x1C frame is received correctly.
- **Mid-frame reset.** Assert `reset` after bit 5 of a 0x29 frame, then release it and send 0x1C → outputs are 0 during reset, no `frame_error` is reported, and `scan_code`=8'h1C with a single `code_valid`.
